banked_register_file: RTL and testbench

BANKED_REGISTER_FILE -- requirements
Module: banked_register_file

---
 rtl/banked_register_file_pkg.sv | 21 ++
 rtl/banked_register_file_bank_map.sv | 28 ++
 rtl/banked_register_file.sv | 97 +++++++++
 tb/tb_banked_register_file.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/banked_register_file_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : banked_register_file_pkg                                        |
// | Brief  : Mode encodings and physical storage geometry of the banked RF   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package banked_register_file_pkg;

    typedef enum logic [1:0] {
        MODE_USR = 2'd0,
        MODE_FIQ = 2'd1,
        MODE_IRQ = 2'd2,
        MODE_SVC = 2'd3
    } mode_e;

    localparam int         c_NUM_PHYS   = 26;
    localparam int         c_PHYS_IDX_W = 5;
    localparam logic [3:0] c_PC_ADDR    = 4'd15;

endpackage
`default_nettype wire

// File: rtl/banked_register_file_bank_map.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rf_bank_map                                                     |
// | Brief  : Logical register + mode to physical storage index               |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module rf_bank_map
    import banked_register_file_pkg::*;
(
    input  mode_e                   i_mode,
    input  logic [3:0]              i_addr,
    output logic [c_PHYS_IDX_W-1:0] o_phys
);

    // Physical layout: 0-14 shared, 15-21 FIQ R8-R14, 22-23 IRQ, 24-25 SVC.
    // Address 15 has no storage; its index is never used by the top.
    always_comb begin
        o_phys = {1'b0, i_addr};
        case (i_mode)
            MODE_FIQ: if (i_addr >= 4'd8 && i_addr <= 4'd14) o_phys = 5'd7 + {1'b0, i_addr};
            MODE_IRQ: if (i_addr == 4'd13 || i_addr == 4'd14) o_phys = 5'd9 + {1'b0, i_addr};
            MODE_SVC: if (i_addr == 4'd13 || i_addr == 4'd14) o_phys = 5'd11 + {1'b0, i_addr};
            default:  o_phys = {1'b0, i_addr};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/banked_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : banked_register_file                                            |
// | Brief  : Mode-banked multi-port register file with write forwarding      |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module banked_register_file
    import banked_register_file_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [1:0]              MODE,
    input  logic [NUM_RD*4-1:0]     RA,
    output logic [NUM_RD*WIDTH-1:0] RD,
    input  logic [NUM_WR-1:0]       WE,
    input  logic [NUM_WR*4-1:0]     WA,
    input  logic [NUM_WR*WIDTH-1:0] WD,
    input  logic [WIDTH-1:0]        R15,
    output logic                    WR_PC
);

    mode_e                   w_mode;
    logic [c_PHYS_IDX_W-1:0] w_wr_idx  [NUM_WR];
    logic                    w_wr_hit  [c_NUM_PHYS];
    logic [WIDTH-1:0]        w_wr_data [c_NUM_PHYS];
    logic                    w_pc_write;
    logic [WIDTH-1:0]        r_mem     [c_NUM_PHYS];
    logic                    r_wr_pc;

    assign w_mode = mode_e'(MODE);
    assign WR_PC  = r_wr_pc;

    generate
        for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
            rf_bank_map u_map (
                .i_mode (w_mode),
                .i_addr (WA[j*4 +: 4]),
                .o_phys (w_wr_idx[j])
            );
        end
    endgenerate

    // Ascending port scan so the highest-indexed port overwrites earlier ones.
    always_comb begin
        for (int p = 0; p < c_NUM_PHYS; p++) begin
            w_wr_hit[p]  = 1'b0;
            w_wr_data[p] = '0;
        end
        w_pc_write = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (WE[j]) begin
                if (WA[j*4 +: 4] == c_PC_ADDR) begin
                    w_pc_write = 1'b1;
                end else begin
                    w_wr_hit[w_wr_idx[j]]  = 1'b1;
                    w_wr_data[w_wr_idx[j]] = WD[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int p = 0; p < c_NUM_PHYS; p++) r_mem[p] <= '0;
            r_wr_pc <= 1'b0;
        end else begin
            for (int p = 0; p < c_NUM_PHYS; p++) begin
                if (w_wr_hit[p]) r_mem[p] <= w_wr_data[p];
            end
            r_wr_pc <= w_pc_write;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [c_PHYS_IDX_W-1:0] w_rd_idx;

            rf_bank_map u_map (
                .i_mode (w_mode),
                .i_addr (RA[k*4 +: 4]),
                .o_phys (w_rd_idx)
            );

            assign RD[k*WIDTH +: WIDTH] =
                (RA[k*4 +: 4] == c_PC_ADDR)          ? R15                 :
                ((BYPASS != 0) && w_wr_hit[w_rd_idx]) ? w_wr_data[w_rd_idx] :
                                                        r_mem[w_rd_idx];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_banked_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_banked_register_file                                         |
// | Brief  : Scenario bench for the banked register file                     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_banked_register_file;

    localparam int         c_W     = 32;
    localparam logic [31:0] c_PCVAL = 32'h1234_5678;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [1:0]     MODE;
    logic [11:0]    RA;
    logic [95:0]    RD;
    logic [1:0]     WE;
    logic [7:0]     WA;
    logic [63:0]    WD;
    logic [31:0]    R15;
    logic           WR_PC;

    int             n_vec  = 0;
    int             n_miss = 0;
    logic [31:0]    exp_q[$];
    logic [31:0]    r_exp;
    logic [31:0]    r_got;

    banked_register_file #(
        .WIDTH(c_W), .NUM_RD(3), .NUM_WR(2), .BYPASS(1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .MODE(MODE), .RA(RA), .RD(RD),
        .WE(WE), .WA(WA), .WD(WD), .R15(R15), .WR_PC(WR_PC)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; tick(); RESET = 1'b0;
        exp_q.push_back(32'd0);
        r_exp = exp_q.pop_front();
        n_vec++;
        if ({31'd0, WR_PC} !== r_exp) begin
            n_miss++; $display("FAIL reset_wr_pc: got %h expected %h", WR_PC, r_exp);
        end
        for (int m = 0; m < 4; m++) begin
            MODE = 2'(m);
            for (int a = 0; a < 16; a++) begin
                RA = {4'd0, 4'd0, 4'(a)};
                exp_q.push_back(a == 15 ? c_PCVAL : 32'd0);
                #1;
                r_exp = exp_q.pop_front();
                n_vec++;
                if (RD[31:0] !== r_exp) begin
                    n_miss++;
                    $display("FAIL reset_read m%0d r%0d: got %h expected %h", m, a, RD[31:0], r_exp);
                end
            end
        end
    endtask

    task automatic test_usr_shared();
        MODE = 2'd0; WE = 2'b01; WA = {4'd0, 4'd3}; WD = {32'd0, 32'h11};
        RA = {4'd0, 4'd3, 4'd0};
        exp_q.push_back(32'h11);
        #1;
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[63:32] !== r_exp) begin
            n_miss++; $display("FAIL usr_bypass_r3: got %h expected %h", RD[63:32], r_exp);
        end
        tick(); WE = 2'b00;
        RA = {4'd0, 4'd0, 4'd3};
        exp_q.push_back(32'h11);
        #1;
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[31:0] !== r_exp) begin
            n_miss++; $display("FAIL usr_r3: got %h expected %h", RD[31:0], r_exp);
        end
        MODE = 2'd1;
        exp_q.push_back(32'h11);
        #1;
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[31:0] !== r_exp) begin
            n_miss++; $display("FAIL fiq_shared_r3: got %h expected %h", RD[31:0], r_exp);
        end
    endtask

    task automatic test_fiq_bank();
        MODE = 2'd1; WE = 2'b01; WA = {4'd0, 4'd8}; WD = {32'd0, 32'hAA};
        tick(); WE = 2'b00;
        RA = {4'd0, 4'd0, 4'd8};
        for (int i = 0; i < 3; i++) begin
            MODE = (i == 1) ? 2'd0 : 2'd1;
            exp_q.push_back((i == 1) ? 32'd0 : 32'hAA);
            #1;
            r_exp = exp_q.pop_front(); n_vec++;
            if (RD[31:0] !== r_exp) begin
                n_miss++; $display("FAIL fiq_bank_r8 step%0d: got %h expected %h", i, RD[31:0], r_exp);
            end
        end
    endtask

    task automatic test_irq_svc_bank();
        logic [31:0] vals [4];
        vals[0] = 32'h300; vals[1] = 32'h0; vals[2] = 32'h100; vals[3] = 32'h200;
        WE = 2'b10; WA = {4'd13, 4'd0};
        MODE = 2'd2; WD = {32'h100, 32'd0}; tick();
        MODE = 2'd3; WD = {32'h200, 32'd0}; tick();
        MODE = 2'd0; WD = {32'h300, 32'd0}; tick();
        WE = 2'b00;
        RA = {4'd13, 4'd0, 4'd0};
        for (int m = 0; m < 4; m++) begin
            MODE = 2'(m);
            exp_q.push_back(vals[m]);
            #1;
            r_exp = exp_q.pop_front(); n_vec++;
            if (RD[95:64] !== r_exp) begin
                n_miss++; $display("FAIL r13_mode%0d: got %h expected %h", m, RD[95:64], r_exp);
            end
        end
    endtask

    task automatic test_same_cycle();
        MODE = 2'd0; WE = 2'b11; WA = {4'd5, 4'd5}; WD = {32'h2, 32'h1};
        RA = {4'd0, 4'd0, 4'd5};
        exp_q.push_back(32'h2);
        #1;
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[31:0] !== r_exp) begin
            n_miss++; $display("FAIL same_cycle_bypass: got %h expected %h", RD[31:0], r_exp);
        end
        tick(); WE = 2'b00;
        exp_q.push_back(32'h2);
        #1;
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[31:0] !== r_exp) begin
            n_miss++; $display("FAIL same_cycle_stored: got %h expected %h", RD[31:0], r_exp);
        end
    endtask

    task automatic test_pc_write();
        MODE = 2'd1; WE = 2'b01; WA = {4'd0, 4'd15}; WD = {32'd0, 32'hDEAD};
        RA = {4'd8, 4'd0, 4'd15};
        exp_q.push_back(c_PCVAL);
        exp_q.push_back(32'hAA);
        exp_q.push_back(32'd0);
        #1;
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[31:0] !== r_exp) begin
            n_miss++; $display("FAIL pc_read_during_write: got %h expected %h", RD[31:0], r_exp);
        end
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[95:64] !== r_exp) begin
            n_miss++; $display("FAIL pc_write_no_bypass: got %h expected %h", RD[95:64], r_exp);
        end
        r_exp = exp_q.pop_front(); n_vec++;
        if ({31'd0, WR_PC} !== r_exp) begin
            n_miss++; $display("FAIL wr_pc_early: got %h expected %h", WR_PC, r_exp);
        end
        tick(); WE = 2'b00;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(c == 0 ? 32'd1 : 32'd0);
            r_exp = exp_q.pop_front(); n_vec++;
            if ({31'd0, WR_PC} !== r_exp) begin
                n_miss++; $display("FAIL wr_pc_cycle%0d: got %h expected %h", c, WR_PC, r_exp);
            end
            if (c == 0) tick();
        end
        exp_q.push_back(32'hAA);
        exp_q.push_back(c_PCVAL);
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[95:64] !== r_exp) begin
            n_miss++; $display("FAIL pc_write_storage: got %h expected %h", RD[95:64], r_exp);
        end
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[31:0] !== r_exp) begin
            n_miss++; $display("FAIL pc_read_after: got %h expected %h", RD[31:0], r_exp);
        end
    endtask

    task automatic test_reset_priority();
        MODE = 2'd0; RESET = 1'b1;
        WE = 2'b11; WA = {4'd15, 4'd1}; WD = {32'hDEAD, 32'h55};
        tick();
        RESET = 1'b0; WE = 2'b00;
        RA = {4'd0, 4'd3, 4'd1};
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[31:0] !== r_exp) begin
            n_miss++; $display("FAIL reset_prio_r1: got %h expected %h", RD[31:0], r_exp);
        end
        r_exp = exp_q.pop_front(); n_vec++;
        if (RD[63:32] !== r_exp) begin
            n_miss++; $display("FAIL reset_prio_r3: got %h expected %h", RD[63:32], r_exp);
        end
        r_exp = exp_q.pop_front(); n_vec++;
        if ({31'd0, WR_PC} !== r_exp) begin
            n_miss++; $display("FAIL reset_prio_wr_pc: got %h expected %h", WR_PC, r_exp);
        end
    endtask

    initial begin
        RESET = 1'b0; MODE = 2'd0; RA = '0; WE = '0; WA = '0; WD = '0; R15 = c_PCVAL;
        r_got = '0;
        test_reset();
        test_usr_shared();
        test_fiq_bank();
        test_irq_svc_bank();
        test_same_cycle();
        test_pc_write();
        test_reset_priority();
        if (exp_q.size() != 0) begin
            n_vec++; n_miss++;
            $display("FAIL scoreboard_drain: got %0d expected %0d", exp_q.size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
